// File: rtl/flappy_pkg.sv
// Shared constants, FSM state type and LFSR-to-row mapping for the pipe generator.
package flappy_pkg;

    localparam int unsigned DEF_COLS = 16;
    localparam int unsigned DEF_ROWS = 16;
    localparam int unsigned ROW_W    = $clog2(DEF_ROWS);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    function automatic int unsigned min_top();
        return 1;
    endfunction

    function automatic int unsigned max_top(input int unsigned rows, input int unsigned gap);
        return rows - gap - 1;
    endfunction

    function automatic int unsigned mid_top(input int unsigned rows, input int unsigned gap);
        return (min_top() + max_top(rows, gap)) / 2;
    endfunction

    // Fold the low LFSR nibble into [min_top, max_top]; values above the range wrap down.
    function automatic int unsigned map_rnd(input logic [7:0] rnd, input int unsigned rows,
                                            input int unsigned gap);
        int unsigned raw;
        int unsigned lo;
        int unsigned hi;
        raw = 32'(rnd[3:0]);
        lo  = min_top();
        hi  = max_top(rows, gap);
        if (raw < lo) begin
            return lo;
        end else if (raw > hi) begin
            return raw - (hi - lo + 1);
        end
        return raw;
    endfunction

endpackage

// File: rtl/pipe_gap_gen_if.sv
// Control inputs and field outputs of the pipe generator.
interface pipe_gap_gen_if #(
    parameter int unsigned COLS  = 16,
    parameter int unsigned ROW_W = 4
);
    logic                    tick;
    logic                    enable;
    logic                    clear;
    logic [7:0]              rnd;
    logic [COLS-1:0]         pipe_present;
    logic [COLS*ROW_W-1:0]   gap_top;
    logic                    score;

    modport master (
        output tick, enable, clear, rnd,
        input  pipe_present, gap_top, score
    );

    modport slave (
        input  tick, enable, clear, rnd,
        output pipe_present, gap_top, score
    );
endinterface

// File: rtl/gap_pick.sv
// Picks the gap row for a newly spawned pipe: map the LFSR byte, then slew-limit it
// against the previous pipe so consecutive gaps stay reachable.
module gap_pick
    import flappy_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned GAP      = 4,
    parameter int unsigned MAXSTEP  = 4,
    parameter int unsigned ROW_BITS = $clog2(ROWS)
) (
    input  logic [7:0]          rnd,
    input  logic [ROW_BITS-1:0] last_gap,
    output logic [ROW_BITS-1:0] next_gap
);

    int unsigned mapped;
    int unsigned last;

    // Both comparisons add to the smaller side so nothing can underflow.
    always_comb begin
        mapped   = map_rnd(rnd, ROWS, GAP);
        last     = 32'(last_gap);
        next_gap = ROW_BITS'(mapped);
        if (mapped > last + MAXSTEP) begin
            next_gap = ROW_BITS'(last + MAXSTEP);
        end else if (mapped + MAXSTEP < last) begin
            next_gap = ROW_BITS'(last - MAXSTEP);
        end
    end

endmodule

// File: rtl/pipe_gap_gen.sv
// Scrolling pipe field for the obstacle course: shifts one column left per game step,
// spawns a pipe at the right edge every SPAWN_PERIOD steps and pulses score when a
// pipe leaves the bird's column.
module pipe_gap_gen
    import flappy_pkg::*;
#(
    parameter int unsigned COLS         = DEF_COLS,
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned GAP          = 4,
    parameter int unsigned SPAWN_PERIOD = 4,
    parameter int unsigned MAXSTEP      = 4,
    parameter int unsigned BIRD_COL     = 3
) (
    input logic           Clock,
    input logic           Reset,
    pipe_gap_gen_if.slave bus
);

    localparam int unsigned ROW_BITS = $clog2(ROWS);
    localparam int unsigned CNT_W    = $clog2(SPAWN_PERIOD);
    localparam logic [ROW_BITS-1:0] MID_GAP  = ROW_BITS'(mid_top(ROWS, GAP));
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ROW_BITS-1:0]        last_gap_q, last_gap_d;
    logic [COLS-1:0]            present_q, present_d;
    logic [COLS*ROW_BITS-1:0]   gap_q, gap_d;
    logic                       score_q, score_d;
    logic                       step;
    logic                       spawn;
    logic [ROW_BITS-1:0]        new_gap;
    logic [ROW_BITS-1:0]        edge_gap;

    gap_pick #(
        .ROWS     (ROWS),
        .GAP      (GAP),
        .MAXSTEP  (MAXSTEP),
        .ROW_BITS (ROW_BITS)
    ) u_gap_pick (
        .rnd      (bus.rnd),
        .last_gap (last_gap_q),
        .next_gap (new_gap)
    );

    // A tick only counts once the FSM has already seen enable for a cycle.
    assign step     = (state_q == StRun) && bus.tick && bus.enable && !bus.clear;
    assign spawn    = step && (cnt_q == CNT_LAST);
    assign edge_gap = spawn ? new_gap : {ROW_BITS{1'b0}};

    // Control FSM: run while enabled, clear always drops back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.enable && !bus.clear) state_d = StRun;
            StRun:   if (!bus.enable || bus.clear) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Field shift, spawn counter and score; clear wins over any step.
    always_comb begin
        cnt_d      = cnt_q;
        last_gap_d = last_gap_q;
        present_d  = present_q;
        gap_d      = gap_q;
        score_d    = 1'b0;
        if (bus.clear) begin
            cnt_d      = '0;
            last_gap_d = MID_GAP;
            present_d  = '0;
            gap_d      = '0;
        end else if (step) begin
            cnt_d     = spawn ? '0 : cnt_q + CNT_W'(1);
            present_d = {spawn, present_q[COLS-1:1]};
            gap_d     = {edge_gap, gap_q[COLS*ROW_BITS-1:ROW_BITS]};
            score_d   = present_q[BIRD_COL];
            if (spawn) begin
                last_gap_d = new_gap;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_gap_q <= MID_GAP;
            present_q  <= '0;
            gap_q      <= '0;
            score_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gap_q <= last_gap_d;
            present_q  <= present_d;
            gap_q      <= gap_d;
            score_q    <= score_d;
        end
    end

    assign bus.pipe_present = present_q;
    assign bus.gap_top      = gap_q;
    assign bus.score        = score_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Bench for pipe_gap_gen: directed stimulus, a column-array reference model checked every
// cycle, plus hand-computed literal expectations and a gap_pick vector table.
module tb_pipe_gap_gen;

    localparam int COLS    = 16;
    localparam int RW      = 4;
    localparam int P       = 4;
    localparam int MAXSTEP = 4;
    localparam int BIRD    = 3;
    localparam int MINT    = 1;
    localparam int MAXT    = 11;
    localparam int MIDT    = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_gap_gen_if #(.COLS(COLS), .ROW_W(RW)) bus ();

    pipe_gap_gen #(
        .COLS         (16),
        .ROWS         (16),
        .GAP          (4),
        .SPAWN_PERIOD (4),
        .MAXSTEP      (4),
        .BIRD_COL     (3)
    ) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    logic [7:0] u_rnd;
    logic [3:0] u_last;
    logic [3:0] u_next;

    gap_pick #(.ROWS(16), .GAP(4), .MAXSTEP(4), .ROW_BITS(4)) u_pick (
        .rnd      (u_rnd),
        .last_gap (u_last),
        .next_gap (u_next)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Reference: gap row straight from the rules, using signed differences.
    function automatic int ref_pick(input int r, input int last);
        int raw;
        int m;
        raw = r % 16;
        if (raw < MINT) m = MINT;
        else if (raw > MAXT) m = raw - (MAXT - MINT + 1);
        else m = raw;
        if (m - last > MAXSTEP) return last + MAXSTEP;
        if (last - m > MAXSTEP) return last - MAXSTEP;
        return m;
    endfunction

    bit m_run;
    bit m_score;
    int m_steps;
    int m_last;
    int m_pres [COLS];
    int m_gap  [COLS];

    function automatic void model_reset();
        m_run   = 1'b0;
        m_score = 1'b0;
        m_steps = 0;
        m_last  = MIDT;
        for (int c = 0; c < COLS; c++) begin
            m_pres[c] = 0;
            m_gap[c]  = 0;
        end
    endfunction

    // Model: steps counted since reset/clear; every P-th step spawns.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || bus.clear) begin
                model_reset();
            end else begin
                bit stp;
                stp     = m_run && bus.tick && bus.enable;
                m_score = stp && (m_pres[BIRD] != 0);
                if (stp) begin
                    m_steps++;
                    for (int c = 0; c < COLS - 1; c++) begin
                        m_pres[c] = m_pres[c+1];
                        m_gap[c]  = m_gap[c+1];
                    end
                    if (m_steps % P == 0) begin
                        m_last          = ref_pick(int'(bus.rnd), m_last);
                        m_pres[COLS-1]  = 1;
                        m_gap[COLS-1]   = m_last;
                    end else begin
                        m_pres[COLS-1]  = 0;
                        m_gap[COLS-1]   = 0;
                    end
                end
                m_run = bus.enable;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            logic [COLS-1:0]    ep;
            logic [COLS*RW-1:0] eg;
            @(negedge clk);
            for (int c = 0; c < COLS; c++) begin
                ep[c]           = (m_pres[c] != 0);
                eg[c*RW +: RW]  = 4'(m_gap[c]);
            end
            check("cyc_present", 64'(bus.pipe_present), 64'(ep));
            check("cyc_gap_top", 64'(bus.gap_top), 64'(eg));
            check("cyc_score", 64'(bus.score), 64'(m_score));
        end
    end

    task automatic run_ticks(input int n);
        bus.tick = 1'b1;
        repeat (n) @(negedge clk);
        bus.tick = 1'b0;
    endtask

    // Clear for one edge, then one idle edge to re-enter RUN.
    task automatic clear_pulse();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] tv_rnd  [7] = '{8'h0E, 8'h00, 8'h0B, 8'h0B, 8'h05, 8'hFF, 8'h0C};
    int         tv_last [7] = '{6, 6, 6, 10, 6, 6, 10};
    int         tv_exp  [7] = '{3, 2, 10, 11, 5, 4, 6};

    initial begin
        bus.tick   = 1'b0;
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        bus.rnd    = 8'h00;
        u_rnd      = 8'h00;
        u_last     = 4'h0;

        // gap_pick vectors and the model's own picker against the same table
        for (int i = 0; i < 7; i++) begin
            u_rnd  = tv_rnd[i];
            u_last = 4'(tv_last[i]);
            #1;
            check("pick_unit", 64'(u_next), 64'(tv_exp[i]));
            check("pick_model", 64'(ref_pick(int'(tv_rnd[i]), tv_last[i])), 64'(tv_exp[i]));
        end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_present", 64'(bus.pipe_present), 64'h0);
        check("reset_gap_top", 64'(bus.gap_top), 64'h0);
        check("reset_score", 64'(bus.score), 64'h0);
        rst_n = 1'b1;

        // Steady spawn with rnd=0x05
        bus.rnd    = 8'h05;
        bus.enable = 1'b1;
        @(negedge clk);
        run_ticks(3);
        check("no_spawn_step3", 64'(bus.pipe_present), 64'h0);
        run_ticks(1);
        check("spawn4_present", 64'(bus.pipe_present), 64'h8000);
        check("spawn4_gap15", 64'(bus.gap_top[60 +: 4]), 64'd5);
        run_ticks(4);
        check("spawn8_present", 64'(bus.pipe_present), 64'h8800);
        check("spawn8_gap11", 64'(bus.gap_top[44 +: 4]), 64'd5);
        check("spawn8_gap15", 64'(bus.gap_top[60 +: 4]), 64'd5);
        run_ticks(8);
        check("step16_present", 64'(bus.pipe_present), 64'h8888);

        // Score: pipe in column 3 moves to column 2
        run_ticks(1);
        check("score_pulse", 64'(bus.score), 64'h1);
        check("score_present", 64'(bus.pipe_present), 64'h4444);
        @(negedge clk);
        check("score_one_cycle", 64'(bus.score), 64'h0);
        run_ticks(1);
        check("score_empty_col", 64'(bus.score), 64'h0);
        check("step18_present", 64'(bus.pipe_present), 64'h2222);

        // Freeze: ticks while disabled are lost
        bus.enable = 1'b0;
        @(negedge clk);
        run_ticks(3);
        check("freeze_present", 64'(bus.pipe_present), 64'h2222);
        check("freeze_gap_top", 64'(bus.gap_top), 64'h0050_0050_0050_0050);

        // Clear together with tick
        bus.enable = 1'b1;
        bus.clear  = 1'b1;
        bus.tick   = 1'b1;
        @(negedge clk);
        bus.clear  = 1'b0;
        bus.tick   = 1'b0;
        check("clear_present", 64'(bus.pipe_present), 64'h0);
        check("clear_gap_top", 64'(bus.gap_top), 64'h0);

        // Map wrap and downward clamp, each from last_gap=6
        bus.rnd = 8'h0E;
        @(negedge clk);
        run_ticks(3);
        check("clear_no_early", 64'(bus.pipe_present), 64'h0);
        run_ticks(1);
        check("map_wrap_gap", 64'(bus.gap_top[60 +: 4]), 64'd3);
        bus.rnd = 8'h00;
        clear_pulse();
        run_ticks(4);
        check("clamp_down_gap", 64'(bus.gap_top[60 +: 4]), 64'd2);

        // Upward clamp then free move
        bus.rnd = 8'h0B;
        clear_pulse();
        run_ticks(4);
        check("clamp_up_gap", 64'(bus.gap_top[60 +: 4]), 64'd10);
        run_ticks(4);
        check("up_next_gap15", 64'(bus.gap_top[60 +: 4]), 64'd11);
        check("up_next_gap11", 64'(bus.gap_top[44 +: 4]), 64'd10);
        run_ticks(8);

        // Asynchronous reset between edges with a score pulse pending
        bus.tick = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_present", 64'(bus.pipe_present), 64'h0);
        check("areset_gap_top", 64'(bus.gap_top), 64'h0);
        check("areset_score", 64'(bus.score), 64'h0);
        bus.tick = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.rnd = 8'h05;
        @(negedge clk);
        run_ticks(3);
        check("post_reset_none", 64'(bus.pipe_present), 64'h0);
        run_ticks(1);
        check("post_reset_spawn", 64'(bus.pipe_present), 64'h8000);
        check("post_reset_gap", 64'(bus.gap_top[60 +: 4]), 64'd5);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
